// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding and
// default sizing constants.
package uart_tx_feeder_pkg;

    // Default FIFO depth in bytes (power of two, 2..256).
    localparam int DEFAULT_DEPTH        = 16;
    // Default number of cycles to wait for tx_busy to rise after wr_en.
    localparam int DEFAULT_BUSY_TIMEOUT = 4;

    // Feeder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage : uart_tx_feeder_pkg

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the producer / UART transmitter and the feeder.
//
// Handshake rules:
//   Producer side: a byte moves on a rising clock edge where
//   in_valid && in_ready. in_ready depends only on registered state, so the
//   producer may look at it before deciding what to present.
//   Transmitter side: wr_en is a one-cycle start strobe; din is valid from
//   the wr_en cycle and held until the next strobe. The transmitter reports
//   activity on tx_busy, and a new strobe is only issued while tx_busy is low.
interface uart_tx_feeder_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       wr_en;
    logic       tx_busy;

    // Environment side: the producer plus the UART transmitter.
    modport master (
        output in_data, in_valid, tx_busy,
        input  in_ready, din, wr_en
    );

    // Feeder side.
    modport slave (
        input  in_data, in_valid, tx_busy,
        output in_ready, din, wr_en
    );

endinterface : uart_tx_feeder_if

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Byte FIFO with wrapping read/write pointers and an occupancy counter.
// Overflowing pushes and underflowing pops are ignored internally so the
// counter can never leave 0..DEPTH.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer and occupancy values; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; never read before written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule : byte_fifo

// File: rtl/uart_tx_feeder.sv
// Buffers bytes from a producer and feeds them one at a time to a UART
// transmitter, waiting for each transfer to finish (or for tx_busy to fail
// to appear within BUSY_TIMEOUT cycles) before starting the next.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                   clk_5m,
    input  logic                   rst_n,
    uart_tx_feeder_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output tx_state_e              state_o
);

    // The timeout counter only has to hold 0..BUSY_TIMEOUT-1.
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    din_q;
    logic          wr_en_q;
    logic          pop;
    logic          push;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;

    // in_ready follows the registered count only, so a pop in the same cycle
    // cannot open a slot at full.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign bus.din      = din_q;
    assign bus.wr_en    = wr_en_q;
    assign state_o      = state_q;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_5m),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, pop request and timeout counter.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop     = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // Transmitter never acknowledged: treat the byte as sent.
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, timeout counter, strobe and output byte registers.
    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            wr_en_q <= 1'b0;
            din_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            wr_en_q <= (state_d == ST_SEND);
            if (pop) begin
                din_q <= fifo_rdata;
            end
        end
    end

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random
// traffic, scored against a byte queue and a simple transmitter model.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int BUSY_TIMEOUT = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #100 clk = ~clk;

  logic [CW-1:0] count;
  tx_state_e state_dbg;
  uart_tx_feeder_if bus_if();

  uart_tx_feeder #(
    .DEPTH(DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_5m(clk),
    .rst_n(rst_n),
    .bus(bus_if),
    .count(count),
    .state_o(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_din = 8'h00;
  bit prev_wr = 1'b0;
  bit pushed_prev = 1'b0;
  logic [CW-1:0] prev_count = '0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc_q[$];
  int last_push_cyc = 0;
  int n_coinc = 0;

  // ---------------- transmitter model controls ----------------
  bit model_en = 1'b0;
  bit force_val = 1'b0;
  bit rand_busy = 1'b0;
  int busy_len = 10;
  int busy_left = 0;
  bit saw_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observes outputs on the falling edge and predicts the push at the next rising edge.
  task automatic monitor();
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      last_din = 8'h00;
      prev_wr = 1'b0;
      pushed_prev = 1'b0;
      prev_count = '0;
      check("rst_count", 32'(count), 0);
      check("rst_wr_en", 32'(bus_if.wr_en), 0);
      check("rst_din", 32'(bus_if.din), 0);
      check("rst_in_ready", 32'(bus_if.in_ready), 1);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      return;
    end
    if (bus_if.wr_en) begin
      check("wr_en_back_to_back", 32'(prev_wr), 0);
      check("wr_en_tx_idle", 32'(bus_if.tx_busy), 0);
      if (exp_q.size() == 0) check("wr_en_unexpected", 1, 0);
      else check("din_order", 32'(bus_if.din), 32'(exp_q.pop_front()));
      if (pushed_prev) begin
        check("push_pop_count", 32'(count), 32'(prev_count));
        n_coinc++;
      end
      last_din = bus_if.din;
      wr_cnt++;
      wr_cyc_q.push_back(cyc);
    end else begin
      check("din_hold", 32'(bus_if.din), 32'(last_din));
    end
    check("count", 32'(count), 32'(exp_q.size()));
    check("in_ready", 32'(bus_if.in_ready), 32'(exp_q.size() != DEPTH));
    prev_count = count;
    prev_wr = bus_if.wr_en;
    pushed_prev = bus_if.in_valid && bus_if.in_ready;
    if (pushed_prev) begin
      exp_q.push_back(bus_if.in_data);
      last_push_cyc = cyc;
    end
  endtask

  // Transmitter stub: tx_busy rises one cycle after wr_en and stays high for
  // busy_len cycles; when disabled, tx_busy is held at force_val.
  task automatic tx_model();
    if (!model_en) begin
      bus_if.tx_busy = force_val;
      busy_left = 0;
      saw_wr = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus_if.tx_busy = 1'b0;
    end else if (saw_wr) begin
      bus_if.tx_busy = 1'b1;
      busy_left = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
      saw_wr = 1'b0;
    end else begin
      bus_if.tx_busy = 1'b0;
    end
    if (model_en && bus_if.wr_en) saw_wr = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    tx_model();
  endtask

  task automatic offer(input logic [7:0] d, input bit v);
    bus_if.in_data = d;
    bus_if.in_valid = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int k = 0;
    while (wr_cnt < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(wr_cnt), 32'(target));
  endtask

  task automatic wait_empty(input int budget, input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  int base;
  int gap;

  initial begin
    offer(8'h00, 1'b0);
    bus_if.tx_busy = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single byte with a responsive transmitter.
    model_en = 1'b1;
    busy_len = 10;
    base = wr_cnt;
    offer(8'hA5, 1'b1);
    step();
    offer(8'h00, 1'b0);
    wait_wr(base + 1, 20, "t1_wr_seen");
    check("t1_latency", 32'(wr_cyc_q[$] - last_push_cyc), 2);
    idle(20);
    check("t1_single_wr", 32'(wr_cnt), 32'(base + 1));
    check("t1_din", 32'(bus_if.din), 32'h A5);
    check("t1_count", 32'(count), 0);

    // Fill to full while the transmitter is held busy.
    model_en = 1'b0;
    force_val = 1'b1;
    step();
    base = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      offer(8'(i), 1'b1);
      step();
    end
    offer(8'h10, 1'b1);
    idle(3);
    offer(8'h00, 1'b0);
    check("t2_count_full", 32'(count), 16);
    check("t2_in_ready", 32'(bus_if.in_ready), 0);
    check("t2_no_wr", 32'(wr_cnt), 32'(base));
    check("t2_refused", 32'(exp_q.size()), 16);

    // Drain in order with random busy lengths.
    model_en = 1'b1;
    rand_busy = 1'b1;
    wait_wr(base + 16, 400, "t3_drain");
    idle(20);
    check("t3_count", 32'(count), 0);

    // tx_busy stuck low: each byte times out and the next one follows.
    model_en = 1'b0;
    force_val = 1'b0;
    idle(2);
    base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      offer(8'($urandom), 1'b1);
      step();
    end
    offer(8'h00, 1'b0);
    wait_wr(base + 3, 60, "t4_sent");
    for (int i = 1; i <= 2; i++) begin
      gap = wr_cyc_q[wr_cyc_q.size() - i] - wr_cyc_q[wr_cyc_q.size() - i - 1];
      check("t4_gap_ok", 32'(gap >= BUSY_TIMEOUT + 1 && gap <= BUSY_TIMEOUT + 3), 1);
    end
    idle(15);
    check("t4_no_dup", 32'(wr_cnt), 32'(base + 3));

    // Continuous push while popping, starting from five stored bytes.
    force_val = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      offer(8'($urandom), 1'b1);
      step();
    end
    n_coinc = 0;
    model_en = 1'b1;
    rand_busy = 1'b0;
    busy_len = 1;
    for (int i = 0; i < 30; i++) begin
      offer(8'($urandom), 1'b1);
      step();
    end
    offer(8'h00, 1'b0);
    check("t5_coincident_seen", 32'(n_coinc > 0), 1);
    wait_empty(600, "t5_drain");
    idle(10);

    // Reset while waiting for the transmitter to finish.
    model_en = 1'b0;
    force_val = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      offer(8'h30 + 8'(i), 1'b1);
      step();
    end
    offer(8'h00, 1'b0);
    model_en = 1'b1;
    busy_len = 10;
    base = wr_cnt;
    wait_wr(base + 1, 20, "t6_first_wr");
    idle(3);
    check("t6_state", 32'(state_dbg), 32'(ST_WAIT_DONE));
    check("t6_count_before", 32'(count), 3);
    rst_n = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 0);
    check("t6_async_wr_en", 32'(bus_if.wr_en), 0);
    idle(2);
    rst_n = 1'b1;
    base = wr_cnt;
    idle(25);
    check("t6_no_wr_after", 32'(wr_cnt), 32'(base));
    check("t6_count_after", 32'(count), 0);

    // Random traffic with occasional stuck-low transmitter windows.
    rand_busy = 1'b1;
    force_val = 1'b0;
    for (int i = 0; i < 300; i++) begin
      model_en = ((i / 60) % 3) != 2;
      offer(8'($urandom), $urandom_range(0, 3) != 0);
      step();
    end
    offer(8'h00, 1'b0);
    model_en = 1'b1;
    wait_empty(1500, "t7_drain");
    idle(20);
    check("t7_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx_feeder
